// File: rtl/fp_add_result_stage.sv
// FP adder result stage: 2-entry in-order FIFO feeding register-file writeback, with sticky
// exception flags. Define FP_RES_CNT_EN to add the 16-bit committed-result counter on res_count.
module fp_add_result_stage #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [3:0]       in_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags,
    input  logic             flags_wr,
    input  logic [3:0]       flags_wdata,
    output logic [3:0]       sticky_flags,
    output logic [15:0]      res_count
);

    localparam int ENT_W = 32 + TAG_W + 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             init_q;
    logic [ENT_W-1:0] head_q, head_d;
    logic [ENT_W-1:0] tail_q, tail_d;
    logic [3:0]       sticky_q, sticky_d;
    logic [ENT_W-1:0] in_entry;
    logic             accept;
    logic             commit;

    assign in_entry = {in_result, in_tag, in_flags};

    // init_q keeps in_ready low during reset while the state sits in EMPTY.
    assign in_ready  = init_q && (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign commit    = out_valid && out_ready;

    assign {out_result, out_tag, out_flags} = out_valid ? head_q : '0;
    assign sticky_flags = sticky_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_d  = in_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && commit) begin
                    head_d = in_entry;
                end else if (accept) begin
                    tail_d  = in_entry;
                    state_d = FULL;
                end else if (commit) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (commit) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // A flag committed in the same cycle as a software write is OR-ed in after the write.
    always_comb begin
        sticky_d = (flags_wr ? flags_wdata : sticky_q) | (commit ? out_flags : 4'b0000);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            init_q   <= 1'b0;
            sticky_q <= 4'b0000;
        end else begin
            state_q  <= state_d;
            init_q   <= 1'b1;
            sticky_q <= sticky_d;
        end
    end

    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

`ifdef FP_RES_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'h0000;
        end else if (commit) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign res_count = cnt_q;
`else
    assign res_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fp_add_result_stage.sv
// Bench for fp_add_result_stage: directed scenarios plus randomized traffic against a queue model.
module tb_fp_add_result_stage;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_result;
    logic [TAG_W-1:0] in_tag;
    logic [3:0]       in_flags;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_flags;
    logic             flags_wr;
    logic [3:0]       flags_wdata;
    logic [3:0]       sticky_flags;
    logic [15:0]      res_count;

    fp_add_result_stage #(.TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_tag       (in_tag),
        .in_flags     (in_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_tag      (out_tag),
        .out_flags    (out_flags),
        .flags_wr     (flags_wr),
        .flags_wdata  (flags_wdata),
        .sticky_flags (sticky_flags),
        .res_count    (res_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      r;
        logic [TAG_W-1:0] t;
        logic [3:0]       f;
    } ent_t;

    // Reference model: entries waiting to be written back, in order.
    ent_t       mq[$];
    logic [3:0] msticky;
    int         mcnt;
    bit         mready_en;
    int         n_cmp = 0;
    int         n_err = 0;

    function automatic ent_t mhead();
        if (mq.size() > 0) return mq[0];
        return '0;
    endfunction

    function automatic logic [15:0] mres();
`ifdef FP_RES_CNT_EN
        return mcnt[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    function automatic logic mready();
        return mready_en && (mq.size() < 2);
    endfunction

    // Advance one clock, updating the model from the inputs presented before the edge.
    task automatic cycle();
        bit   acc;
        bit   com;
        ent_t h;
        ent_t e;
        acc = in_valid && mready();
        com = (mq.size() > 0) && out_ready;
        h   = mhead();
        e.r = in_result;
        e.t = in_tag;
        e.f = in_flags;
        @(posedge clk);
        msticky = (flags_wr ? flags_wdata : msticky) | (com ? h.f : 4'b0000);
        if (com) begin
            void'(mq.pop_front());
            mcnt++;
        end
        if (acc) mq.push_back(e);
        mready_en = 1'b1;
        #1;
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        in_result   = '0;
        in_tag      = '0;
        in_flags    = '0;
        out_ready   = 1'b0;
        flags_wr    = 1'b0;
        flags_wdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        mq.delete();
        msticky   = 4'b0000;
        mcnt      = 0;
        mready_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        mq.delete();
        msticky = 4'b0000;
        mcnt = 0;
        mready_en = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        n_cmp++;
        if ({out_valid, out_result, out_tag, out_flags} !== '0) begin
            n_err++; $display("FAIL reset_out got=%b/%h/%h/%h exp=all zero", out_valid, out_result, out_tag, out_flags);
        end
        n_cmp++;
        if (sticky_flags !== 4'b0000 || res_count !== 16'h0000) begin
            n_err++; $display("FAIL reset_sticky_cnt got=%b/%h exp=0/0", sticky_flags, res_count);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready_before_edge got=%b exp=0", in_ready);
        end
        cycle();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready_after_edge got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_single_pass();
        in_valid  = 1'b1;
        in_result = 32'h3FC00000;
        in_tag    = 5'd3;
        in_flags  = 4'b0000;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, out_result, out_tag, out_flags} !== {1'b1, 32'h3FC00000, 5'd3, 4'b0000}) begin
            n_err++; $display("FAIL single_out got=%b/%h/%h/%b exp=1/3fc00000/03/0000", out_valid, out_result, out_tag, out_flags);
        end
        cycle();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sticky_flags !== 4'b0000) begin
            n_err++; $display("FAIL single_drain got vld=%b rdy=%b sticky=%b exp=0/1/0000", out_valid, in_ready, sticky_flags);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_result = 32'h40490FDB; in_tag = 5'd7;  in_flags = 4'b0001;
        cycle();
        in_result = 32'hC0000000; in_tag = 5'd12; in_flags = 4'b0100;
        cycle();
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_full_ready got=%b exp=0", in_ready);
        end
        in_result = 32'h7F800000; in_tag = 5'd30; in_flags = 4'b1000;
        cycle();
        n_cmp++;
        if ({out_valid, out_result, out_tag, out_flags} !== {1'b1, 32'h40490FDB, 5'd7, 4'b0001}) begin
            n_err++; $display("FAIL bp_hold got=%b/%h/%h/%b exp=1/40490fdb/07/0001", out_valid, out_result, out_tag, out_flags);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        n_cmp++;
        if ({out_valid, out_result, out_tag, out_flags} !== {1'b1, 32'hC0000000, 5'd12, 4'b0100}) begin
            n_err++; $display("FAIL bp_second got=%b/%h/%h/%b exp=1/c0000000/0c/0100", out_valid, out_result, out_tag, out_flags);
        end
        cycle();
        n_cmp++;
        if (out_valid !== 1'b0 || sticky_flags !== 4'b0101) begin
            n_err++; $display("FAIL bp_drain got vld=%b sticky=%b exp=0/0101", out_valid, sticky_flags);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_clear_commit();
        flags_wr    = 1'b1;
        flags_wdata = 4'b1000;
        in_valid    = 1'b1;
        in_result   = 32'h3F800000; in_tag = 5'd9; in_flags = 4'b0010;
        out_ready   = 1'b0;
        cycle();
        n_cmp++;
        if (sticky_flags !== 4'b1000) begin
            n_err++; $display("FAIL clr_preset got=%b exp=1000", sticky_flags);
        end
        in_valid    = 1'b0;
        flags_wdata = 4'b0000;
        out_ready   = 1'b1;
        cycle();
        n_cmp++;
        if (sticky_flags !== 4'b0010) begin
            n_err++; $display("FAIL clr_commit got=%b exp=0010", sticky_flags);
        end
        flags_wr  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_streaming();
        logic [15:0] exp_cnt;
        apply_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_result = $urandom;
            in_tag    = TAG_W'($urandom);
            in_flags  = 4'($urandom);
            cycle();
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || {out_result, out_tag, out_flags} !== mhead()) begin
                n_err++; $display("FAIL stream_c%0d got rdy=%b vld=%b ent=%h exp=1/1/%h", i, in_ready, out_valid, {out_result, out_tag, out_flags}, mhead());
            end
        end
        in_valid = 1'b0;
        cycle();
`ifdef FP_RES_CNT_EN
        exp_cnt = 16'd10;
`else
        exp_cnt = 16'd0;
`endif
        n_cmp++;
        if (res_count !== exp_cnt || out_valid !== 1'b0 || sticky_flags !== msticky) begin
            n_err++; $display("FAIL stream_end got cnt=%h vld=%b sticky=%b exp=%h/0/%b", res_count, out_valid, sticky_flags, exp_cnt, msticky);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        flags_wr = 1'b1; flags_wdata = 4'b1111;
        cycle();
        flags_wr  = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_result = $urandom; in_tag = TAG_W'(i + 1); in_flags = 4'b1010;
            cycle();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0 || sticky_flags !== 4'b1111) begin
            n_err++; $display("FAIL mrst_pre got rdy=%b sticky=%b exp=0/1111", in_ready, sticky_flags);
        end
        rst_n = 1'b0;
        mq.delete(); msticky = 4'b0000; mcnt = 0; mready_en = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || sticky_flags !== 4'b0000 || in_ready !== 1'b0 || res_count !== 16'h0000) begin
            n_err++; $display("FAIL mrst_async got vld=%b sticky=%b rdy=%b cnt=%h exp=0/0000/0/0000", out_valid, sticky_flags, in_ready, res_count);
        end
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cycle();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sticky_flags !== 4'b0000) begin
            n_err++; $display("FAIL mrst_after got rdy=%b vld=%b sticky=%b exp=1/0/0000", in_ready, out_valid, sticky_flags);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_result   = $urandom;
            in_tag      = TAG_W'($urandom);
            in_flags    = 4'($urandom);
            out_ready   = ($urandom_range(0, 2) != 0);
            flags_wr    = ($urandom_range(0, 7) == 0);
            flags_wdata = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            cycle();
            n_cmp++;
            if ({out_valid, out_result, out_tag, out_flags} !== {(mq.size() > 0), mhead()}) begin
                n_err++; $display("FAIL rand_out_%0d got=%b/%h exp=%b/%h", i, out_valid, {out_result, out_tag, out_flags}, (mq.size() > 0), mhead());
            end
            n_cmp++;
            if (in_ready !== mready() || sticky_flags !== msticky || res_count !== mres()) begin
                n_err++; $display("FAIL rand_ctl_%0d got rdy=%b sticky=%b cnt=%h exp=%b/%b/%h", i, in_ready, sticky_flags, res_count, mready(), msticky, mres());
            end
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        apply_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (mcnt < 65535) begin
            in_result = mcnt;
            cycle();
        end
        n_cmp++;
        if (res_count !== mres()) begin
            n_err++; $display("FAIL wrap_ffff got=%h exp=%h", res_count, mres());
        end
        cycle();
        n_cmp++;
        if (res_count !== mres() || mcnt != 65536) begin
            n_err++; $display("FAIL wrap_zero got=%h exp=%h", res_count, mres());
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_backpressure();
        test_clear_commit();
        test_streaming();
        test_mid_reset();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_add_result_stage.md
FP_ADD_RESULT_STAGE -- requirements
Module: fp_add_result_stage

Interface
REQ-001 SHALL have parameter TAG_W, default 5: width of the destination-register tag carried with each result.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  adder result and flags present this cycle.
REQ-005 SHALL have port in_ready  output  1  stage can accept a result this cycle.
REQ-006 SHALL have port in_result  input  32  single-precision sum or difference.
REQ-007 SHALL have port in_tag  input  TAG_W  destination tag.
REQ-008 SHALL have port in_flags  input  4  {invalid, overflow, underflow, inexact}.
REQ-009 SHALL have port out_valid  output  1  head entry valid.
REQ-010 SHALL have port out_ready  input  1  consumer (register-file writeback) accepts the head entry.
REQ-011 SHALL have port out_result  output  32  head entry result.
REQ-012 SHALL have port out_tag  output  TAG_W  head entry tag.
REQ-013 SHALL have port out_flags  output  4  head entry flags.
REQ-014 SHALL have port flags_wr  input  1  software write of the sticky flags.
REQ-015 SHALL have port flags_wdata  input  4  value for flags_wr; all-zero clears.
REQ-016 SHALL have port sticky_flags  output  4  accrued exception flags, same bit order as in_flags.
REQ-017 SHALL have port res_count  output  16  committed-result counter (see REQ-031).

Function
REQ-018 SHALL hold results in a 2-entry FIFO with states EMPTY, ONE, FULL; accept = in_valid & in_ready; commit = out_valid & out_ready.
REQ-019 SHALL drive in_ready = 1 in EMPTY and ONE and 0 in FULL, decoded from registered state only, with no combinational path from out_ready.
REQ-020 SHALL transition EMPTY->ONE on accept; ONE->FULL on accept without commit; ONE->EMPTY on commit without accept; FULL->ONE on commit; ONE stays ONE on simultaneous accept and commit.
REQ-021 SHALL have a latency of 1 cycle: an entry accepted at edge N appears on out_* with out_valid=1 after edge N.
REQ-022 SHALL keep out_result, out_tag, out_flags and out_valid constant while out_valid=1 and out_ready=0.
REQ-023 SHALL preserve ordering: commits occur in accept order and no entry is dropped or duplicated.
REQ-024 SHALL drive out_valid=0 in EMPTY, with out_result, out_tag and out_flags all zero.
REQ-025 SHALL compute sticky flags at each edge as next = (flags_wr ? flags_wdata : sticky) | (commit ? out_flags : 4'b0000), so a flag committed in the same cycle as a clear survives.
REQ-026 SHALL make flags enter sticky_flags only on commit, never on accept.
REQ-027 SHALL pass in_result through unmodified, performing no rounding or reformatting.

Reset
REQ-028 SHALL, while rst_n=0, force state EMPTY, in_ready=0, out_valid=0, out_result, out_tag, out_flags and sticky_flags all zero, and res_count=0, independent of clk.
REQ-029 SHALL drive in_ready=1 from the first rising edge after rst_n deasserts.
REQ-030 SHALL discard buffered entries on reset asserted mid-operation, commit none of them, and lose their flags.

Configuration
REQ-031 SHALL, with macro FP_RES_CNT_EN defined, increment res_count by 1 on every commit and wrap from 16'hFFFF to 16'h0000.
REQ-032 SHALL, without FP_RES_CNT_EN, tie res_count to 16'h0000 and instantiate no counter register.

Verification
REQ-033 SHALL cover single pass: accept 32'h3FC00000, tag 3, flags 4'b0000, out_ready=1 -> out_valid one cycle later with same data, then EMPTY, sticky_flags 0.
REQ-034 SHALL cover backpressure: out_ready=0, accept two results (flags 4'b0001, then 4'b0100) -> in_ready=0 on third cycle, out_* hold the first entry; release out_ready -> both commit in order, sticky_flags=4'b0101.
REQ-035 SHALL cover simultaneous clear and commit: sticky_flags=4'b1000, flags_wr=1 with flags_wdata=0 in the same cycle as commit of flags 4'b0010 -> sticky_flags=4'b0010.
REQ-036 SHALL cover streaming: in_valid=1 and out_ready=1 for 10 cycles -> 10 commits, state ONE throughout, in_ready never 0, res_count=10 with FP_RES_CNT_EN defined and 0 without.
REQ-037 SHALL cover mid-operation reset: FULL with out_ready=0, pulse rst_n low between edges -> out_valid=0 and sticky_flags=0 immediately, in_ready=1 after first edge, no commit observed.
REQ-038 SHALL cover wrap: preload res_count to 16'hFFFF via 65535 commits, one more commit -> res_count=16'h0000.
